cpu_sysid_reader: RTL and testbench
===================================

# cpu_sysid_reader

Avalon-MM read master that interrogates the system-ID slave after reset or on request. It reads the ID word (word address 0) and the build timestamp (word address 1), latches both, and compares them against the expected values the FPGA image was built with. It sits beside the Nios CPU on the same interconnect and gives hardware a pass/fail indication that the loaded SOPC image matches the software build, before any software runs.

## Interface
Parameters:
- EXPECTED_ID, 32'd2, expected contents of word address 0.
- EXPECTED_TS, 32'd1498619909, expected contents of word address 1.
- TIMEOUT_CYCLES, 255, maximum cycles per read transaction from `avm_read` assertion to `avm_readdatavalid`. Range 1..65535.
- AUTO_START, 1. When 1, a check starts automatically on the first cycle after reset release.

Ports:
- clock  in  1  sole clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that requests a check. Ignored while `busy` is high.
- avm_address  out  1  word address presented to the sysid slave.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall. The request is held while this input is high.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  qualifies `avm_readdata`.
- busy  out  1  high while a check is in progress.
- done  out  1  one-cycle pulse when a check completes or times out.
- id_ok  out  1  sticky result: latched ID equals EXPECTED_ID.
- ts_ok  out  1  sticky result: latched timestamp equals EXPECTED_TS.
- pass  out  1  `id_ok & ts_ok & !timeout`.
- timeout  out  1  sticky flag: a transaction exceeded TIMEOUT_CYCLES.
- sys_id  out  32  latched ID word.
- sys_timestamp  out  32  latched timestamp word.

## Operation
- Reset values:
  - All outputs are 0, including `sys_id` and `sys_timestamp`.
  - FSM is in IDLE.
  - Timeout counter is 0.
- FSM states: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, FIN.
- IDLE:
  - Moves to RD_ID on `start`, or on the first post-reset cycle when AUTO_START=1.
  - On entry to RD_ID, clears `id_ok`, `ts_ok`, `timeout` and `pass`.
  - `sys_id` and `sys_timestamp` are not cleared.
- RD_ID:
  - Drives `avm_read`=1 and `avm_address`=0.
  - Goes to WT_ID on the first cycle with `avm_waitrequest`=0.
  - If `avm_readdatavalid` is high in that same cycle, the data is accepted there and the FSM goes straight to RD_TS.
- WT_ID:
  - Drives `avm_read`=0.
  - On `avm_readdatavalid`: latch `sys_id`, set `id_ok` = (data == EXPECTED_ID), go to RD_TS.
- RD_TS / WT_TS: same as RD_ID / WT_ID, with `avm_address`=1. The data latches into `sys_timestamp` and sets `ts_ok`. Then go to FIN.
- FIN:
  - Pulses `done`, with `pass` already valid in that cycle.
  - Returns to IDLE.
- `busy` is high in every state except IDLE.
- Timeout:
  - A 16-bit counter clears on entry to each RD_* state and increments every cycle in RD_* and WT_* states.
  - When the count reaches TIMEOUT_CYCLES without valid data: set `timeout`, deassert `avm_read`, go to FIN.
  - The `*_ok` flag of the unfinished word stays 0.
- `readdatavalid` arriving while in IDLE or FIN is ignored.
- `start` arriving while `busy` is high is dropped, not queued.
- Reset asserted mid-check aborts immediately: `avm_read` drops asynchronously and all outputs return to their reset values.

## Timing
- `avm_read` and `avm_address` are registered outputs.
- With zero wait states and one-cycle read latency, one check takes 6 cycles from `start` to `done`:
  - start sampled (1) → RD_ID (2) → WT_ID (3) → RD_TS (4) → WT_TS (5) → FIN (6).
- A slave returning data combinationally in the accept cycle shortens each word by one cycle.
- `id_ok`, `ts_ok` and the latched words update on the clock edge after their `readdatavalid` cycle.
- `pass` is combinational from the sticky flags, so it is valid coincident with `done`.
- Exactly one read is outstanding at a time. Each read is a single-word transaction; there are no bursts.

## Test plan
- AUTO_START=1, slave returns 2 and 1498619909 with latency 1:
  - `avm_read` is issued at address 0, then at address 1.
  - `done` pulses 6 cycles after reset release.
  - `pass`=1, `sys_id`=2, `sys_timestamp`=1498619909.
- Slave returns ID 3: `id_ok`=0, `ts_ok`=1, `pass`=0, `sys_id`=3.
- `avm_waitrequest` held high for 4 cycles on each read:
  - `avm_read` and `avm_address` stay stable throughout the stall.
  - `done` arrives 8 cycles later than the zero-wait case; `pass`=1.
- Slave never asserts `readdatavalid`, TIMEOUT_CYCLES=10:
  - `timeout`=1 and `done` pulses 10 cycles after the first `avm_read`.
  - `id_ok`=0, `pass`=0.
  - Only address 0 is ever issued.
- `start` pulsed while `busy`: no second check runs and exactly one `done` pulse occurs. A `start` after `done` reruns the check and clears the previous flags first.
- Reset asserted during WT_TS:
  - `avm_read`, `busy` and all flags go to 0 asynchronously.
  - After release with AUTO_START=0, no read occurs until `start`.

Source files
------------

// File: rtl/cpu_sysid_reader.sv
// rtl/cpu_sysid_reader.sv - Avalon-MM read master that checks the sysid slave against build-time values
module cpu_sysid_reader #(
    parameter logic [31:0] EXPECTED_ID    = 32'd2,
    parameter logic [31:0] EXPECTED_TS    = 32'd1498619909,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] sys_id,
    output logic [31:0] sys_timestamp
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        WT_ID = 3'd2,
        RD_TS = 3'd3,
        WT_TS = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        auto_pending;
    logic        in_xfer;
    logic        limit_hit;
    logic        take_id;
    logic        take_ts;
    logic        expire;

    always_comb begin
        state_next = state;
        take_id    = 1'b0;
        take_ts    = 1'b0;
        expire     = 1'b0;
        in_xfer    = (state == RD_ID) || (state == WT_ID) || (state == RD_TS) || (state == WT_TS);
        cnt_inc    = cnt + 16'd1;
        // cnt_inc counts the current cycle, so the limit fires on the TIMEOUT_CYCLES-th cycle
        limit_hit  = in_xfer && (cnt_inc == TIMEOUT_LIMIT);
        case (state)
            IDLE: begin
                if (start || auto_pending) state_next = RD_ID;
            end
            RD_ID: begin
                if (!avm_waitrequest && avm_readdatavalid) begin
                    take_id    = 1'b1;
                    state_next = RD_TS;
                end else if (limit_hit) begin
                    expire     = 1'b1;
                    state_next = FIN;
                end else if (!avm_waitrequest) begin
                    state_next = WT_ID;
                end
            end
            WT_ID: begin
                if (avm_readdatavalid) begin
                    take_id    = 1'b1;
                    state_next = RD_TS;
                end else if (limit_hit) begin
                    expire     = 1'b1;
                    state_next = FIN;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest && avm_readdatavalid) begin
                    take_ts    = 1'b1;
                    state_next = FIN;
                end else if (limit_hit) begin
                    expire     = 1'b1;
                    state_next = FIN;
                end else if (!avm_waitrequest) begin
                    state_next = WT_TS;
                end
            end
            WT_TS: begin
                if (avm_readdatavalid) begin
                    take_ts    = 1'b1;
                    state_next = FIN;
                end else if (limit_hit) begin
                    expire     = 1'b1;
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 16'd0;
            auto_pending  <= (AUTO_START != 0);
            avm_read      <= 1'b0;
            avm_address   <= 1'b0;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            timeout       <= 1'b0;
            sys_id        <= 32'd0;
            sys_timestamp <= 32'd0;
        end else begin
            state        <= state_next;
            auto_pending <= 1'b0;
            avm_read     <= (state_next == RD_ID) || (state_next == RD_TS);
            avm_address  <= (state_next == RD_TS) || (state_next == WT_TS);
            if (((state_next == RD_ID) || (state_next == RD_TS)) && (state_next != state)) begin
                cnt <= 16'd0;
            end else if (in_xfer) begin
                cnt <= cnt_inc;
            end
            // Latched words survive a rerun; only the verdict flags are cleared
            if ((state == IDLE) && (state_next == RD_ID)) begin
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (take_id) begin
                sys_id <= avm_readdata;
                id_ok  <= (avm_readdata == EXPECTED_ID);
            end
            if (take_ts) begin
                sys_timestamp <= avm_readdata;
                ts_ok         <= (avm_readdata == EXPECTED_TS);
            end
            if (expire) timeout <= 1'b1;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);
    assign pass = id_ok & ts_ok & ~timeout;

endmodule

// File: tb/tb_cpu_sysid_reader.sv
// tb/tb_cpu_sysid_reader.sv - self-checking bench for cpu_sysid_reader with a behavioural sysid slave
module tb_cpu_sysid_reader;

    localparam logic [31:0] EXP_ID = 32'd2;
    localparam logic [31:0] EXP_TS = 32'd1498619909;
    localparam int T      = 10;
    localparam int M_LAT1 = 0;
    localparam int M_COMB = 1;
    localparam int M_NONE = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0;
    logic start_m = 1'b0;
    logic mon_clr = 1'b0;
    always #5 clock = ~clock;

    logic        av_addr [2];
    logic        av_rd   [2];
    logic        av_wr   [2];
    logic        av_rv   [2];
    logic [31:0] av_rdata[2];
    logic        busy[2], done[2], id_ok[2], ts_ok[2], pass[2], timeout[2];
    logic [31:0] sys_id[2], sys_ts[2];

    int          stall_cfg[2];
    int          mode_cfg [2][2];
    logic [31:0] mem      [2][2];
    logic        spur     [2];
    logic [31:0] spur_data[2];

    int          stall_cnt[2];
    logic        pend[2], pend_addr[2];
    int          issue_n[2];
    logic [15:0] issue_seq[2];
    logic        prev_stall[2], prev_addr[2], unstable[2];
    int          done_n[2];

    int checks = 0;
    int errors = 0;
    logic [31:0] m_sys_id = 32'd0;
    logic [31:0] m_sys_ts = 32'd0;

    cpu_sysid_reader #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(255), .AUTO_START(1)) u_auto (
        .clock(clock), .reset(reset), .start(start_a),
        .avm_address(av_addr[0]), .avm_read(av_rd[0]), .avm_waitrequest(av_wr[0]),
        .avm_readdata(av_rdata[0]), .avm_readdatavalid(av_rv[0]),
        .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .pass(pass[0]),
        .timeout(timeout[0]), .sys_id(sys_id[0]), .sys_timestamp(sys_ts[0]));

    cpu_sysid_reader #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(T), .AUTO_START(0)) u_dut (
        .clock(clock), .reset(reset), .start(start_m),
        .avm_address(av_addr[1]), .avm_read(av_rd[1]), .avm_waitrequest(av_wr[1]),
        .avm_readdata(av_rdata[1]), .avm_readdatavalid(av_rv[1]),
        .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .pass(pass[1]),
        .timeout(timeout[1]), .sys_id(sys_id[1]), .sys_timestamp(sys_ts[1]));

    // Slave: stalls stall_cfg cycles per read, then answers next cycle, same cycle, or never
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            av_wr[k]    = av_rd[k] && (stall_cnt[k] < stall_cfg[k]);
            av_rv[k]    = spur[k];
            av_rdata[k] = spur_data[k];
            if (mode_cfg[k][av_addr[k]] == M_COMB && av_rd[k] && !av_wr[k]) begin
                av_rv[k]    = 1'b1;
                av_rdata[k] = mem[k][av_addr[k]];
            end else if (pend[k]) begin
                av_rv[k]    = 1'b1;
                av_rdata[k] = mem[k][pend_addr[k]];
            end
        end
    end

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (mon_clr) begin
                stall_cnt[k] <= 0; pend[k] <= 1'b0; pend_addr[k] <= 1'b0;
                issue_n[k] <= 0; issue_seq[k] <= 16'd0; prev_stall[k] <= 1'b0;
                prev_addr[k] <= 1'b0; unstable[k] <= 1'b0; done_n[k] <= 0;
            end else begin
                stall_cnt[k] <= (av_rd[k] && av_wr[k]) ? stall_cnt[k] + 1 : 0;
                pend[k]      <= av_rd[k] && !av_wr[k] && (mode_cfg[k][av_addr[k]] == M_LAT1);
                pend_addr[k] <= av_addr[k];
                if (av_rd[k] && !av_wr[k]) begin
                    issue_n[k]   <= issue_n[k] + 1;
                    issue_seq[k] <= {issue_seq[k][14:0], av_addr[k]};
                end
                prev_stall[k] <= av_rd[k] && av_wr[k];
                prev_addr[k]  <= av_addr[k];
                if (prev_stall[k] && !(av_rd[k] && av_addr[k] == prev_addr[k])) unstable[k] <= 1'b1;
                if (done[k]) done_n[k] <= done_n[k] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int m);
        return (m == M_COMB) ? 0 : 1;
    endfunction

    task automatic run_check(input int s, input int m0, input int m1,
                             input logic [31:0] d0, input logic [31:0] d1, input bit extra);
        bit resp0, resp1, acc0, acc1, e_id, e_ts, e_to;
        int w0, w1, e_lat, edges;
        stall_cfg[1] = s; mode_cfg[1][0] = m0; mode_cfg[1][1] = m1;
        mem[1][0] = d0; mem[1][1] = d1;
        acc0  = (s + 1 <= T);
        resp0 = (m0 != M_NONE) && (s + 1 + lat_of(m0) <= T);
        w0    = resp0 ? s + 1 + lat_of(m0) : T;
        acc1  = resp0 && acc0;
        resp1 = resp0 && (m1 != M_NONE) && (s + 1 + lat_of(m1) <= T);
        w1    = !resp0 ? 0 : (resp1 ? s + 1 + lat_of(m1) : T);
        if (resp0) m_sys_id = d0;
        if (resp1) m_sys_ts = d1;
        e_id  = resp0 && (d0 == EXP_ID);
        e_ts  = resp1 && (d1 == EXP_TS);
        e_to  = !resp0 || !resp1;
        e_lat = 1 + w0 + w1;

        @(negedge clock) mon_clr = 1'b1;
        @(negedge clock) mon_clr = 1'b0;
        start_m = 1'b1;
        @(posedge clock) edges = 1;
        @(negedge clock) start_m = 1'b0;
        chk("cleared_id_ok", id_ok[1], 1'b0);
        chk("cleared_timeout", timeout[1], 1'b0);
        chk("busy_running", busy[1], 1'b1);
        while (done[1] !== 1'b1 && edges < 300) begin
            start_m = extra && (edges == 2);
            @(posedge clock) edges++;
            @(negedge clock);
        end
        start_m = 1'b0;
        chk("latency", edges, e_lat);
        chk("id_ok", id_ok[1], e_id);
        chk("ts_ok", ts_ok[1], e_ts);
        chk("timeout", timeout[1], e_to);
        chk("pass", pass[1], e_id && e_ts && !e_to);
        chk("sys_id", sys_id[1], m_sys_id);
        chk("sys_timestamp", sys_ts[1], m_sys_ts);
        if (extra) begin
            start_m = 1'b1;
            @(negedge clock) start_m = 1'b0;
        end
        repeat (8) @(negedge clock);
        chk("idle_after", busy[1], 1'b0);
        chk("done_pulses", done_n[1], 1);
        chk("reads_issued", issue_n[1], acc0 + acc1);
        chk("read_order", issue_seq[1], acc1 ? 16'h0001 : 16'h0000);
        chk("stall_stable", unstable[1], 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;
        for (int k = 0; k < 2; k++) begin
            stall_cfg[k] = 0; mode_cfg[k][0] = M_LAT1; mode_cfg[k][1] = M_LAT1;
            mem[k][0] = EXP_ID; mem[k][1] = EXP_TS; spur[k] = 1'b0; spur_data[k] = 32'd0;
        end
        mon_clr = 1'b1;
        repeat (3) @(negedge clock);
        mon_clr = 1'b0;
        chk("rst_busy", busy[1], 1'b0);
        chk("rst_read", av_rd[1], 1'b0);
        chk("rst_done", done[1], 1'b0);
        chk("rst_sys_id", sys_id[1], 32'd0);
        chk("rst_sys_ts", sys_ts[1], 32'd0);
        chk("rst_flags", {id_ok[1], ts_ok[1], pass[1], timeout[1]}, 4'b0000);
        chk("rst_auto_busy", busy[0], 1'b0);

        reset = 1'b0;
        edges = 0;
        while (done[0] !== 1'b1 && edges < 300) begin
            @(posedge clock) edges++;
            @(negedge clock);
        end
        chk("auto_latency", edges, 5);
        chk("auto_pass", pass[0], 1'b1);
        chk("auto_sys_id", sys_id[0], EXP_ID);
        chk("auto_sys_ts", sys_ts[0], EXP_TS);
        chk("auto_reads", issue_n[0], 2);
        chk("auto_order", issue_seq[0], 16'h0001);

        repeat (10) @(negedge clock);
        chk("manual_no_autostart", issue_n[1], 0);
        chk("manual_idle", busy[1], 1'b0);

        run_check(0, M_LAT1, M_LAT1, EXP_ID, EXP_TS, 1'b0);
        run_check(0, M_LAT1, M_LAT1, 32'd3, EXP_TS, 1'b0);
        run_check(4, M_LAT1, M_LAT1, EXP_ID, EXP_TS, 1'b0);
        run_check(0, M_NONE, M_LAT1, EXP_ID, EXP_TS, 1'b0);
        run_check(0, M_LAT1, M_LAT1, EXP_ID, EXP_TS, 1'b1);
        run_check(0, M_COMB, M_COMB, EXP_ID, EXP_TS, 1'b0);
        run_check(0, M_LAT1, M_NONE, EXP_ID, EXP_TS, 1'b0);
        run_check(9, M_LAT1, M_LAT1, EXP_ID, EXP_TS, 1'b0);
        run_check(9, M_COMB, M_COMB, EXP_ID, 32'd7, 1'b0);

        @(negedge clock) begin spur[1] = 1'b1; spur_data[1] = 32'h1234_5678; end
        @(negedge clock) spur[1] = 1'b0;
        @(negedge clock);
        chk("spurious_sys_id", sys_id[1], m_sys_id);
        chk("spurious_busy", busy[1], 1'b0);

        for (int i = 0; i < 12; i++) begin
            int s, m0, m1, r;
            logic [31:0] d0, d1;
            s  = $urandom_range(0, 4);
            if (s == 4) s = 9;
            r  = $urandom_range(0, 5); m0 = (r < 3) ? M_LAT1 : (r < 5) ? M_COMB : M_NONE;
            r  = $urandom_range(0, 5); m1 = (r < 3) ? M_LAT1 : (r < 5) ? M_COMB : M_NONE;
            d0 = $urandom_range(0, 1) ? EXP_ID : 32'($urandom);
            d1 = $urandom_range(0, 1) ? EXP_TS : 32'($urandom);
            run_check(s, m0, m1, d0, d1, 1'b0);
        end

        stall_cfg[1] = 0; mode_cfg[1][0] = M_LAT1; mode_cfg[1][1] = M_NONE;
        mem[1][0] = EXP_ID; mem[1][1] = EXP_TS;
        @(negedge clock) start_m = 1'b1;
        @(negedge clock) start_m = 1'b0;
        repeat (3) @(negedge clock);
        chk("wt_ts_busy", busy[1], 1'b1);
        chk("wt_ts_id_ok", id_ok[1], 1'b1);
        reset = 1'b1;
        #1;
        chk("async_busy", busy[1], 1'b0);
        chk("async_id_ok", id_ok[1], 1'b0);
        chk("async_sys_id", sys_id[1], 32'd0);
        chk("async_read", av_rd[1], 1'b0);
        m_sys_id = 32'd0; m_sys_ts = 32'd0;
        @(negedge clock) reset = 1'b0;

        stall_cfg[1] = 5; mode_cfg[1][1] = M_LAT1;
        @(negedge clock) start_m = 1'b1;
        @(negedge clock) start_m = 1'b0;
        chk("stalled_read", av_rd[1], 1'b1);
        reset = 1'b1;
        #1;
        chk("async_read_drop", av_rd[1], 1'b0);
        mon_clr = 1'b1;
        @(negedge clock) reset = 1'b0;
        @(negedge clock) mon_clr = 1'b0;
        repeat (12) @(negedge clock);
        chk("post_reset_no_read", issue_n[1], 0);
        chk("post_reset_idle", busy[1], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
